// File: rtl/hazard_ctrl_if.sv
// D-stage hazard descriptor in, stall and forwarding selects out.
// The decode side drives through master; hazard_ctrl sits on slave.
interface hazard_ctrl_if;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [4:0] wa;
    logic       tuse_rs0;
    logic       tuse_rs1;
    logic       tuse_rt0;
    logic       tuse_rt1;
    logic [2:0] res;
    logic       flush_e;
    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic       fwd_rt_m;

    modport master (
        output ra1, ra2, wa, tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, res, flush_e,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );

    modport slave (
        input  ra1, ra2, wa, tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, res, flush_e,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage core: shadows the writers in E/M/W with a
// Tnew countdown and derives the stall and all forwarding selects from them.
module hazard_ctrl (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
        logic [2:0] res;
        logic [1:0] tnew;
    } rec_t;

    rec_t e_q, m_q, w_q;
    rec_t e_d, m_d, w_d;
    logic stall_w;

    function automatic logic [4:0] wa_eff(input rec_t r);
        return (r.res != RES_NW) ? r.wa : 5'd0;
    endfunction

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic [1:0] tnew_init(input logic [2:0] res);
        case (res)
            RES_ALU: return 2'd1;
            RES_DM:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // A D-stage read stalls while the producer's result arrives later than needed.
    function automatic logic raw_hazard(input logic [4:0] a, input logic used,
                                        input logic tuse, input rec_t r);
        return used && (a != 5'd0) && (a == wa_eff(r)) && (r.tnew > {1'b0, tuse});
    endfunction

    function automatic logic [1:0] sel_d(input logic [4:0] a, input rec_t e, input rec_t m);
        if (a == 5'd0) return 2'd0;
        if (a == wa_eff(e) && e.tnew == 2'd0 && e.res == RES_PC) return 2'd1;
        if (a == wa_eff(m) && m.tnew == 2'd0 && (m.res == RES_ALU || m.res == RES_PC))
            return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] a, input rec_t m, input rec_t w);
        if (a == 5'd0) return 2'd0;
        if (a == wa_eff(m) && m.tnew == 2'd0 && (m.res == RES_ALU || m.res == RES_PC))
            return 2'd1;
        if (a == wa_eff(w) && w.tnew == 2'd0) return 2'd2;
        return 2'd0;
    endfunction

    logic rs_used, rt_used, rs_tuse, rt_tuse;
    assign rs_used = hz.tuse_rs0 | hz.tuse_rs1;
    assign rt_used = hz.tuse_rt0 | hz.tuse_rt1;
    assign rs_tuse = ~hz.tuse_rs0;
    assign rt_tuse = ~hz.tuse_rt0;

    assign stall_w = raw_hazard(hz.ra1, rs_used, rs_tuse, e_q)
                   | raw_hazard(hz.ra1, rs_used, rs_tuse, m_q)
                   | raw_hazard(hz.ra2, rt_used, rt_tuse, e_q)
                   | raw_hazard(hz.ra2, rt_used, rt_tuse, m_q);

    always_comb begin
        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = tnew_dec(m_q.tnew);
        e_d      = '0;
        // Stall and flush collapse into the same single bubble.
        if (!stall_w && !hz.flush_e) begin
            e_d.rs   = hz.ra1;
            e_d.rt   = hz.ra2;
            e_d.wa   = hz.wa;
            e_d.res  = hz.res;
            e_d.tnew = tnew_init(hz.res);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign hz.stall    = stall_w;
    assign hz.fwd_rs_d = sel_d(hz.ra1, e_q, m_q);
    assign hz.fwd_rt_d = sel_d(hz.ra2, e_q, m_q);
    assign hz.fwd_rs_e = sel_e(e_q.rs, m_q, w_q);
    assign hz.fwd_rt_e = sel_e(e_q.rt, m_q, w_q);
    assign hz.fwd_rt_m = (m_q.rt != 5'd0) && (m_q.rt == wa_eff(w_q)) && (w_q.tnew == 2'd0);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised + directed bench for hazard_ctrl; the reference model tracks each
// issued instruction by the cycle it entered E and derives readiness from its age.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hz ();
    hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hz));

    typedef struct {
        int rs; int rt; int wa; int res;
        bit trs0; bit trs1; bit trt0; bit trt1;
    } instr_t;
    typedef struct { instr_t ins; int ecyc; } flight_t;

    flight_t fl[$];
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int exp_stall;
    int obs_stall, obs_rs_d, obs_rt_d, obs_rs_e, obs_rt_e, obs_rt_m;

    task automatic check_val(input string tag, input logic [31:0] got, input int expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, expv);
        end
    endtask

    function automatic instr_t mk(int rs, int rt, int wa, int res,
                                  bit trs0, bit trs1, bit trt0, bit trt1);
        instr_t i;
        i.rs = rs; i.rt = rt; i.wa = wa; i.res = res;
        i.trs0 = trs0; i.trs1 = trs1; i.trt0 = trt0; i.trt1 = trt1;
        return i;
    endfunction

    // Cycles after entering E until the result exists: ALU end of E, DM end of M.
    function automatic int lat(int res);
        return (res == 1) ? 1 : (res == 2) ? 2 : 0;
    endfunction
    function automatic int weff(instr_t i);
        return (i.res != 0) ? i.wa : 0;
    endfunction
    function automatic int tnew_of(flight_t f);
        int t = lat(f.ins.res) - (cyc - f.ecyc);
        return (t < 0) ? 0 : t;
    endfunction
    function automatic bit find_age(int age, output flight_t f);
        f.ecyc = -1;
        f.ins = mk(0, 0, 0, 0, 0, 0, 0, 0);
        foreach (fl[k]) if (cyc - fl[k].ecyc == age) begin f = fl[k]; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic int m_op_stall(int a, bit t0, bit t1);
        flight_t f;
        int tuse = t0 ? 0 : 1;
        if (!(t0 | t1) || a == 0) return 0;
        for (int age = 0; age < 2; age++)
            if (find_age(age, f) && weff(f.ins) == a && tnew_of(f) > tuse) return 1;
        return 0;
    endfunction
    function automatic int m_fwd_d(int a);
        flight_t f;
        if (a == 0) return 0;
        if (find_age(0, f) && weff(f.ins) == a && tnew_of(f) == 0 && f.ins.res == 3) return 1;
        if (find_age(1, f) && weff(f.ins) == a && tnew_of(f) == 0 &&
            (f.ins.res == 1 || f.ins.res == 3)) return 2;
        return 0;
    endfunction
    function automatic int m_fwd_e(bit use_rt);
        flight_t e, f;
        int a;
        if (!find_age(0, e)) return 0;
        a = use_rt ? e.ins.rt : e.ins.rs;
        if (a == 0) return 0;
        if (find_age(1, f) && weff(f.ins) == a && tnew_of(f) == 0 &&
            (f.ins.res == 1 || f.ins.res == 3)) return 1;
        if (find_age(2, f) && weff(f.ins) == a && tnew_of(f) == 0) return 2;
        return 0;
    endfunction
    function automatic int m_fwd_m();
        flight_t m, w;
        if (!find_age(1, m) || m.ins.rt == 0) return 0;
        if (find_age(2, w) && weff(w.ins) == m.ins.rt && tnew_of(w) == 0) return 1;
        return 0;
    endfunction

    task automatic apply(input instr_t d, input bit flush);
        hz.ra1 = 5'(d.rs); hz.ra2 = 5'(d.rt); hz.wa = 5'(d.wa); hz.res = 3'(d.res);
        hz.tuse_rs0 = d.trs0; hz.tuse_rs1 = d.trs1;
        hz.tuse_rt0 = d.trt0; hz.tuse_rt1 = d.trt1;
        hz.flush_e = flush;
    endtask

    task automatic compare_now(input instr_t d);
        exp_stall = m_op_stall(d.rs, d.trs0, d.trs1) | m_op_stall(d.rt, d.trt0, d.trt1);
        obs_stall = 32'(hz.stall);
        obs_rs_d = 32'(hz.fwd_rs_d); obs_rt_d = 32'(hz.fwd_rt_d);
        obs_rs_e = 32'(hz.fwd_rs_e); obs_rt_e = 32'(hz.fwd_rt_e);
        obs_rt_m = 32'(hz.fwd_rt_m);
        check_val("stall", 32'(hz.stall), exp_stall);
        if (exp_stall == 0) begin
            check_val("fwd_rs_d", 32'(hz.fwd_rs_d), m_fwd_d(d.rs));
            check_val("fwd_rt_d", 32'(hz.fwd_rt_d), m_fwd_d(d.rt));
        end
        check_val("fwd_rs_e", 32'(hz.fwd_rs_e), m_fwd_e(1'b0));
        check_val("fwd_rt_e", 32'(hz.fwd_rt_e), m_fwd_e(1'b1));
        check_val("fwd_rt_m", 32'(hz.fwd_rt_m), m_fwd_m());
    endtask

    task automatic cycle(input instr_t d, input bit flush);
        apply(d, flush);
        #3;
        compare_now(d);
        $display("cyc %0d D rs=%0d rt=%0d wa=%0d res=%0d flush=%0d -> stall=%0d d=%0d/%0d e=%0d/%0d m=%0d",
                 cyc, d.rs, d.rt, d.wa, d.res, flush, obs_stall, obs_rs_d, obs_rt_d,
                 obs_rs_e, obs_rt_e, obs_rt_m);
        @(posedge clk);
        if (exp_stall == 0 && !flush) fl.push_back('{ins: d, ecyc: cyc + 1});
        cyc++;
        while (fl.size() > 0 && cyc - fl[0].ecyc > 2) void'(fl.pop_front());
        #1;
    endtask

    instr_t nop, cur;
    bit hold;

    initial begin
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset held with a load in D: everything must read zero.
        reset = 1'b0;
        apply(mk(29, 0, 8, 2, 0, 1, 0, 0), 1'b0);
        #3;
        compare_now(mk(29, 0, 8, 2, 0, 1, 0, 0));
        @(posedge clk); #1;
        compare_now(mk(29, 0, 8, 2, 0, 1, 0, 0));
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) cycle(nop, 1'b0);

        // Load-use into E.
        cycle(mk(29, 0, 8, 2, 0, 1, 0, 0), 1'b0);
        cycle(mk(8, 1, 9, 1, 0, 1, 0, 1), 1'b0);
        check_val("lu_stall", 32'(obs_stall), 1);
        cycle(mk(8, 1, 9, 1, 0, 1, 0, 1), 1'b0);
        check_val("lu_release", 32'(obs_stall), 0);
        cycle(nop, 1'b0);
        check_val("lu_fwd_w", 32'(obs_rs_e), 2);

        // Branch after ALU.
        cycle(mk(1, 2, 3, 1, 0, 1, 0, 1), 1'b0);
        cycle(mk(3, 4, 0, 0, 1, 0, 1, 0), 1'b0);
        check_val("br_stall", 32'(obs_stall), 1);
        cycle(mk(3, 4, 0, 0, 1, 0, 1, 0), 1'b0);
        check_val("br_fwd_m", 32'(obs_rs_d), 2);

        // jal then jr $31.
        cycle(mk(0, 0, 31, 3, 0, 0, 0, 0), 1'b0);
        cycle(mk(31, 0, 0, 0, 1, 0, 0, 0), 1'b0);
        check_val("jr_stall", 32'(obs_stall), 0);
        check_val("jr_fwd_e", 32'(obs_rs_d), 1);

        // Newer M write beats older W write.
        cycle(mk(1, 2, 5, 1, 0, 1, 0, 1), 1'b0);
        cycle(mk(6, 0, 5, 1, 0, 1, 0, 0), 1'b0);
        cycle(mk(5, 7, 0, 0, 0, 1, 0, 1), 1'b0);
        check_val("pri_stall", 32'(obs_stall), 0);
        cycle(nop, 1'b0);
        check_val("pri_fwd_m", 32'(obs_rs_e), 1);

        // Non-writing producer and $0 producer never interact.
        cycle(mk(1, 0, 5, 0, 0, 1, 0, 0), 1'b0);
        cycle(mk(5, 0, 0, 0, 1, 0, 0, 0), 1'b0);
        check_val("nw_stall", 32'(obs_stall), 0);
        check_val("nw_fwd_d", 32'(obs_rs_d), 0);
        cycle(mk(1, 0, 0, 2, 0, 1, 0, 0), 1'b0);
        cycle(mk(0, 0, 0, 0, 1, 0, 1, 0), 1'b0);
        check_val("r0_stall", 32'(obs_stall), 0);

        // Store data forwarded from W into M.
        cycle(mk(1, 2, 10, 1, 0, 1, 0, 1), 1'b0);
        cycle(mk(29, 10, 0, 0, 0, 1, 0, 1), 1'b0);
        cycle(nop, 1'b0);
        cycle(nop, 1'b0);
        check_val("sw_fwd_m", 32'(obs_rt_m), 1);

        // Flushed load leaves nothing to wait for.
        cycle(mk(29, 0, 8, 2, 0, 1, 0, 0), 1'b1);
        cycle(mk(8, 0, 9, 1, 0, 1, 0, 0), 1'b0);
        check_val("fl_stall", 32'(obs_stall), 0);
        cycle(nop, 1'b0);
        check_val("fl_fwd_e", 32'(obs_rs_e), 0);

        // Asynchronous reset in the middle of a stall.
        cycle(mk(29, 0, 8, 2, 0, 1, 0, 0), 1'b0);
        apply(mk(8, 0, 9, 1, 0, 1, 0, 0), 1'b0);
        #2;
        check_val("mr_pre", 32'(hz.stall), 1);
        reset = 1'b0;
        fl.delete();
        #1;
        compare_now(mk(8, 0, 9, 1, 0, 1, 0, 0));
        check_val("mr_drop", 32'(obs_stall), 0);
        @(posedge clk); #1;
        cyc++;
        reset = 1'b1;
        #1;

        // Random stream: stalled instructions are re-presented, as in the core.
        hold = 1'b0;
        cur = nop;
        for (int n = 0; n < 600; n++) begin
            if (!hold)
                cur = mk($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                         $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom));
            cycle(cur, ($urandom_range(0, 9) == 0));
            hold = (exp_stall != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
